// File: rtl/digital_theremin_cpu_cpu_ocimem_ctrl.sv
// Nios II OCI debug memory controller: arbitrates the JTAG command port
// (jdo + take_* strobes) and the CPU Avalon-MM slave onto one single-port
// 32-bit debug RAM plus the monitor handshake register.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   jdo[37:0]                 JTAG command/data word, valid with a take_* strobe
//   take_action_ocimem_a      load MonAReg / control flags, optional read
//   take_no_action_ocimem_a   MonAReg+1 then read
//   take_action_ocimem_b      write jdo[34:3] at MonAReg, then MonAReg+1
//   address[AW:0]             CPU word address, MSB selects the control register
//   chipselect, read, write, debugaccess, byteenable, writedata
//                             Avalon-MM slave request
//   readdata, waitrequest     Avalon-MM slave response
//   MonDReg                   JTAG read-back data
//   monitor_ready/error/go    monitor handshake flags
module digital_theremin_cpu_cpu_ocimem_ctrl #(
  parameter int unsigned AW = 8,
  parameter INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [37:0]   jdo,
  input  logic          take_action_ocimem_a,
  input  logic          take_no_action_ocimem_a,
  input  logic          take_action_ocimem_b,
  input  logic [AW:0]   address,
  input  logic          chipselect,
  input  logic          read,
  input  logic          write,
  input  logic          debugaccess,
  input  logic [3:0]    byteenable,
  input  logic [31:0]   writedata,
  output logic [31:0]   readdata,
  output logic          waitrequest,
  output logic [31:0]   MonDReg,
  output logic          monitor_ready,
  output logic          monitor_error,
  output logic          monitor_go
);

  localparam int unsigned DEPTH = 2 ** AW;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CPU_RD   = 3'd1;
  localparam logic [2:0] S_CPU_RD2  = 3'd2;
  localparam logic [2:0] S_JTAG_RD  = 3'd3;
  localparam logic [2:0] S_JTAG_CAP = 3'd4;

  // The RAM image, when given, is preloaded by the memory macro flow.
  if (INIT_FILE != "") begin : g_init_image
  end

  logic [2:0]    state_q, state_d;
  logic          live_q;
  logic [AW-1:0] mon_a_q, mon_a_d;
  logic [31:0]   readdata_q;
  logic          jtag_pending_q, jtag_pending_d;
  logic          jtag_is_wr_q, jtag_is_wr_d;
  logic [31:0]   jtag_wdata_q, jtag_wdata_d;
  logic          rearm_q, rearm_d;
  logic          ready_d, error_d, go_d;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   ram_q;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_we;
  logic [31:0]   ram_wdata;

  logic          cpu_rd, cpu_wr, reg_sel;
  logic          reg_wr, cap_cpu, cap_jtag;
  logic          jtag_wr_done, jtag_cap_done, jtag_dispatch;
  logic          strobe_queues;
  logic          unused_jdo;

  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  // CPU requests are ignored until the first clock after reset release.
  assign reg_sel = address[AW];
  assign cpu_rd  = live_q & chipselect & read;
  assign cpu_wr  = live_q & chipselect & write & ~read;

  // FSM next state and RAM port control; CPU always wins over JTAG in IDLE.
  always_comb begin
    state_d       = state_q;
    ram_addr      = mon_a_q;
    ram_we        = 4'h0;
    ram_wdata     = jtag_wdata_q;
    reg_wr        = 1'b0;
    cap_cpu       = 1'b0;
    cap_jtag      = 1'b0;
    jtag_wr_done  = 1'b0;
    jtag_cap_done = 1'b0;
    jtag_dispatch = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_rd) begin
          if (!reg_sel) begin
            ram_addr = address[AW-1:0];
            state_d  = S_CPU_RD;
          end
        end else if (cpu_wr) begin
          if (reg_sel) begin
            reg_wr = 1'b1;
          end else if (debugaccess) begin
            ram_addr  = address[AW-1:0];
            ram_we    = byteenable;
            ram_wdata = writedata;
          end
        end else if (live_q && jtag_pending_q) begin
          if (jtag_is_wr_q) begin
            ram_we       = 4'hF;
            jtag_wr_done = 1'b1;
          end else begin
            jtag_dispatch = 1'b1;
            state_d       = S_JTAG_RD;
          end
        end
      end
      S_CPU_RD: begin
        cap_cpu = 1'b1;
        state_d = S_CPU_RD2;
      end
      S_CPU_RD2: begin
        state_d = S_IDLE;
      end
      S_JTAG_RD: begin
        cap_jtag = 1'b1;
        state_d  = S_JTAG_CAP;
      end
      S_JTAG_CAP: begin
        jtag_cap_done = 1'b1;
        state_d       = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign strobe_queues = take_action_ocimem_b | take_no_action_ocimem_a |
                         (take_action_ocimem_a & jdo[34]);

  // JTAG queue, address register and monitor flags next values.
  always_comb begin
    mon_a_d        = mon_a_q;
    jtag_pending_d = jtag_pending_q;
    jtag_is_wr_d   = jtag_is_wr_q;
    jtag_wdata_d   = jtag_wdata_q;
    rearm_d        = rearm_q;
    ready_d        = monitor_ready;
    error_d        = monitor_error;
    go_d           = monitor_go;

    if (jtag_wr_done) begin
      mon_a_d = mon_a_q + AW'(1);
    end
    if (take_action_ocimem_a) begin
      mon_a_d = jdo[AW+25:26];
    end else if (take_no_action_ocimem_a) begin
      mon_a_d = mon_a_d + AW'(1);
    end

    // A read in flight must not swallow a strobe that landed after dispatch.
    if (jtag_dispatch) begin
      rearm_d = 1'b0;
    end
    if (jtag_wr_done || (jtag_cap_done && !rearm_q)) begin
      jtag_pending_d = 1'b0;
    end

    // Newest strobe replaces whatever op is queued.
    if (strobe_queues) begin
      jtag_pending_d = 1'b1;
      rearm_d        = 1'b1;
    end
    if (take_action_ocimem_b) begin
      jtag_is_wr_d = 1'b1;
      jtag_wdata_d = jdo[34:3];
    end else if (take_no_action_ocimem_a || (take_action_ocimem_a && jdo[34])) begin
      jtag_is_wr_d = 1'b0;
    end

    // JTAG updates first so a same-cycle CPU register write wins.
    if (take_action_ocimem_a && jdo[25]) begin
      ready_d = 1'b0;
      error_d = 1'b0;
    end
    if (take_action_ocimem_a && jdo[23]) begin
      go_d = 1'b1;
    end
    if (reg_wr) begin
      if (writedata[0]) ready_d = 1'b1;
      if (writedata[1]) error_d = 1'b1;
      if (writedata[2]) go_d    = 1'b0;
    end
  end

  // State and control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      live_q         <= 1'b0;
      mon_a_q        <= '0;
      MonDReg        <= '0;
      readdata_q     <= '0;
      jtag_pending_q <= 1'b0;
      jtag_is_wr_q   <= 1'b0;
      jtag_wdata_q   <= '0;
      rearm_q        <= 1'b0;
      monitor_ready  <= 1'b0;
      monitor_error  <= 1'b0;
      monitor_go     <= 1'b0;
    end else begin
      state_q        <= state_d;
      live_q         <= 1'b1;
      mon_a_q        <= mon_a_d;
      jtag_pending_q <= jtag_pending_d;
      jtag_is_wr_q   <= jtag_is_wr_d;
      jtag_wdata_q   <= jtag_wdata_d;
      rearm_q        <= rearm_d;
      monitor_ready  <= ready_d;
      monitor_error  <= error_d;
      monitor_go     <= go_d;
      if (cap_cpu) begin
        readdata_q <= ram_q;
      end
      if (cap_jtag) begin
        MonDReg <= ram_q;
      end
    end
  end

  // Single-port debug RAM, byte-writable, registered read (read-first).
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_we[b]) begin
        mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end
    end
    ram_q <= mem[ram_addr];
  end

  // Register reads answer in the request cycle; RAM reads come from readdata_q.
  always_comb begin
    readdata = readdata_q;
    if (state_q == S_IDLE && cpu_rd && reg_sel) begin
      readdata = {29'b0, monitor_go, monitor_error, monitor_ready};
    end
  end

  // Stall: held in reset, RAM reads until CPU_RD2, any request while busy.
  always_comb begin
    waitrequest = 1'b0;
    if (!live_q) begin
      waitrequest = 1'b1;
    end else begin
      case (state_q)
        S_IDLE:    waitrequest = chipselect & read & ~reg_sel;
        S_CPU_RD2: waitrequest = chipselect & write & ~read;
        default:   waitrequest = chipselect & (read | write);
      endcase
    end
  end

endmodule
